st_packet_arbiter: RTL and testbench

Packet-level round-robin arbiter sharing one Avalon-ST transmit stream between NUM_REQ packet sources, for example the MAC header adder output and a locally generated reply path. A grant is locked from SOP to EOP so packets never interleave. Per-requester enables come from the register controller, and per-requester packet counters are exposed for status reads. The arbiter sits directly in front of the transmit stream output.

---
 rtl/st_packet_arbiter_pkg.sv | 17 +
 rtl/st_packet_arbiter_skid_buffer.sv | 67 ++++++
 rtl/st_packet_arbiter.sv | 166 ++++++++++++++++
 tb/tb_st_packet_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/st_packet_arbiter_pkg.sv
// Shared defaults, FSM encodings and the grant index type for the packet arbiter.
// The index type is sized for the largest supported requester count (8).
package st_packet_arbiter_pkg;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_EMPTY_WIDTH = 2;
    localparam int DEF_CNT_WIDTH   = 16;
    localparam int MAX_REQ         = 8;
    localparam int IDX_W           = $clog2(MAX_REQ);

    typedef logic [IDX_W-1:0] req_idx_t;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/st_packet_arbiter_skid_buffer.sv
// Two-entry stream buffer with a registered ready: in_ready never depends
// combinationally on out_ready, and out_* hold steady while stalled.
module st_skid_buffer
    import st_packet_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + DEF_EMPTY_WIDTH + 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_payload,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_payload,
    output logic             out_valid,
    input  logic             out_ready
);

    logic             skid_valid;
    logic             skid_next;
    logic             accept;
    logic             load_out;
    logic [WIDTH-1:0] skid_payload;

    assign accept   = in_valid && in_ready;
    assign load_out = out_ready || !out_valid;

    // in_ready is only high while the skid slot is empty, so a drain and an
    // accept never coincide.
    always_comb begin
        skid_next = skid_valid;
        if (load_out) begin
            skid_next = 1'b0;
        end else if (accept) begin
            skid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
            out_payload <= '0;
        end else begin
            skid_valid <= skid_next;
            in_ready   <= !skid_next;
            if (load_out) begin
                if (skid_valid) begin
                    out_payload <= skid_payload;
                    out_valid   <= 1'b1;
                end else if (accept) begin
                    out_payload <= in_payload;
                    out_valid   <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !load_out) begin
            skid_payload <= in_payload;
        end
    end

endmodule

// File: rtl/st_packet_arbiter.sv
// Packet-level round-robin arbiter: one Avalon-ST output shared by NUM_REQ
// sources, grant locked SOP..EOP, orphan beats flushed, per-source EOP counters.
module st_packet_arbiter
    import st_packet_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int EMPTY_WIDTH = DEF_EMPTY_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_REQ*EMPTY_WIDTH-1:0] in_empty,
    input  logic [NUM_REQ-1:0]             in_valid,
    input  logic [NUM_REQ-1:0]             in_sop,
    input  logic [NUM_REQ-1:0]             in_eop,
    output logic [NUM_REQ-1:0]             in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [EMPTY_WIDTH-1:0]         out_empty,
    output logic                           out_valid,
    output logic                           out_sop,
    output logic                           out_eop,
    input  logic                           out_ready,
    input  logic [NUM_REQ-1:0]             req_enable,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ*CNT_WIDTH-1:0]   pkt_count,
    output logic                           orphan_drop
);

    localparam int PW = DATA_WIDTH + EMPTY_WIDTH + 2;

    logic [0:0]             state;
    req_idx_t               gidx;
    req_idx_t               last_grant;
    req_idx_t               win_idx;
    logic                   win_found;
    logic                   run;
    logic [NUM_REQ-1:0]     cand;
    logic                   sel_valid;
    logic                   sel_sop;
    logic                   sel_eop;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [EMPTY_WIDTH-1:0] sel_empty;
    logic                   skid_in_ready;
    logic                   skid_in_valid;
    logic [PW-1:0]          skid_out;
    logic                   acc_eop;
    logic [CNT_WIDTH-1:0]   cnt [NUM_REQ];

    assign cand = in_valid & in_sop & req_enable;

    // First candidate at or after last_grant+1, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && cand[i] && i == (int'(last_grant) + 1 + k) % NUM_REQ) begin
                    win_found = 1'b1;
                    win_idx   = req_idx_t'(i);
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        sel_empty = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_idx_t'(i) == gidx) begin
                sel_valid = in_valid[i];
                sel_sop   = in_sop[i];
                sel_eop   = in_eop[i];
                sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_empty = in_empty[i*EMPTY_WIDTH +: EMPTY_WIDTH];
            end
        end
    end

    assign skid_in_valid = (state == ST_LOCKED) && sel_valid;
    assign acc_eop       = skid_in_valid && skid_in_ready && sel_eop;

    // In IDLE only enabled non-SOP beats are taken, and they are thrown away;
    // run keeps every ready low until the first clock after reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (state == ST_LOCKED) begin
                in_ready[i] = grant[i] && skid_in_ready;
            end else begin
                in_ready[i] = run && req_enable[i] && !in_sop[i];
            end
        end
    end

    assign orphan_drop = (state == ST_IDLE) && run && |(in_valid & ~in_sop & req_enable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            gidx       <= '0;
            grant      <= '0;
            last_grant <= req_idx_t'(NUM_REQ - 1);
            run        <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state <= ST_LOCKED;
                        gidx  <= win_idx;
                        grant <= NUM_REQ'(1) << win_idx;
                    end
                end
                default: begin
                    if (acc_eop) begin
                        state      <= ST_IDLE;
                        grant      <= '0;
                        last_grant <= gidx;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc_eop && grant[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pkt_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
        end
    end

    st_skid_buffer #(
        .WIDTH(PW)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .in_payload ({sel_data, sel_empty, sel_sop, sel_eop}),
        .in_valid   (skid_in_valid),
        .in_ready   (skid_in_ready),
        .out_payload(skid_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    assign {out_data, out_empty, out_sop, out_eop} = skid_out;

endmodule

// File: tb/tb_st_packet_arbiter.sv
// Scoreboard bench for st_packet_arbiter: directed packets push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_st_packet_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int EW = 2;
    localparam int CW = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [EW-1:0] e;
        logic          s;
        logic          eo;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*DW-1:0]  in_data;
    logic [NR*EW-1:0]  in_empty;
    logic [NR-1:0]     in_valid, in_sop, in_eop, in_ready;
    logic [DW-1:0]     out_data;
    logic [EW-1:0]     out_empty;
    logic              out_valid, out_sop, out_eop, out_ready;
    logic [NR-1:0]     req_enable, grant;
    logic [NR*CW-1:0]  pkt_count;
    logic              orphan_drop;

    st_packet_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_empty(in_empty), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .out_data(out_data), .out_empty(out_empty), .out_valid(out_valid),
        .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready),
        .req_enable(req_enable), .grant(grant), .pkt_count(pkt_count),
        .orphan_drop(orphan_drop)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    out_beats = 0;
    int    orphan_cnt = 0;
    int    acc_cyc[$];
    beat_t exp_q[$];
    logic [NR-1:0] gtrace[$];
    bit    trace_on = 0;
    bit    sb_en = 1;
    bit    stall_prev = 0;
    logic [DW+EW+2:0] stall_saved;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic beat_t mk(input int r, input int p, input int b, input int n);
        beat_t bt;
        bt.d  = {8'(8'hA0 + r), 8'(p), 16'(b)};
        bt.e  = EW'(b);
        bt.s  = (b == 0);
        bt.eo = (b == n - 1);
        return bt;
    endfunction

    task automatic push_pkt(input int r, input int p, input int n);
        for (int b = 0; b < n; b++) exp_q.push_back(mk(r, p, b, n));
    endtask

    task automatic send_pkt(input int r, input int p, input int n);
        beat_t bt;
        bit    acc;
        int    t;
        for (int b = 0; b < n; b++) begin
            bt = mk(r, p, b, n);
            in_valid[r] = 1'b1;
            in_data[r*DW +: DW] = bt.d;
            in_empty[r*EW +: EW] = bt.e;
            in_sop[r] = bt.s;
            in_eop[r] = bt.eo;
            acc = 0;
            t = 0;
            while (!acc && t < 200) begin
                @(negedge clk);
                acc = in_ready[r];
                @(posedge clk);
                #1;
                t++;
            end
            if (!acc) begin
                check("send_timeout", 64'(t), 64'(0));
                break;
            end
            acc_cyc.push_back(cyc);
        end
        in_valid[r] = 1'b0;
        in_sop[r] = 1'b0;
        in_eop[r] = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        exp_q.delete();
        stall_prev = 0;
        cycles(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_grant"}, 64'(grant), 64'(0));
        check({tag, "_out_ctrl"}, 64'({out_valid, out_sop, out_eop, orphan_drop}), 64'(0));
        check({tag, "_out_fields"}, 64'({out_data, out_empty}), 64'(0));
        check({tag, "_pkt_count"}, 64'(pkt_count), 64'(0));
    endtask

    // Monitor: stall stability, scoreboard pops, orphan pulse count.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev)
                check("stall_stable", 64'({out_valid, out_data, out_empty, out_sop, out_eop}), 64'(stall_saved));
            stall_prev = out_valid && !out_ready;
            stall_saved = {out_valid, out_data, out_empty, out_sop, out_eop};
            if (out_valid && out_ready) begin
                out_beats++;
                if (sb_en) begin
                    if (exp_q.size() == 0) check("unexpected_beat", 64'(out_data), 64'(0));
                    else check("beat", 64'({out_data, out_empty, out_sop, out_eop}), 64'(exp_q.pop_front()));
                end
            end
            if (orphan_drop) orphan_cnt++;
        end
        if (trace_on) gtrace.push_back(grant);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, l0, f1, b0;
        bit bad;
        rst = 1'b1;
        in_data = '0; in_empty = '0; in_valid = '0; in_sop = '0; in_eop = '0;
        out_ready = 1'b1;
        req_enable = 2'b11;
        cycles(2);
        check_all_zero("reset");
        rst = 1'b0;
        cycles(2);

        // Both requesters offer a 3-beat packet at once: 0 first, then 1.
        trace_on = 1;
        push_pkt(0, 1, 3);
        push_pkt(1, 1, 3);
        fork
            send_pkt(0, 1, 3);
            send_pkt(1, 1, 3);
        join
        cycles(4);
        trace_on = 0;
        f = -1; l0 = -1; f1 = -1;
        foreach (gtrace[i]) begin
            if (f < 0 && gtrace[i] != 0) f = i;
            if (gtrace[i] == 2'b01) l0 = i;
            if (f1 < 0 && gtrace[i] == 2'b10) f1 = i;
        end
        check("first_grant", (f >= 0) ? 64'(gtrace[f]) : 64'(0), 64'(2'b01));
        check("grant_gap", 64'(f1 - l0), 64'(2));
        check("t1_count0", 64'(pkt_count[0 +: CW]), 64'(1));
        check("t1_count1", 64'(pkt_count[CW +: CW]), 64'(1));
        check("t1_drained", 64'(exp_q.size()), 64'(0));

        // Five single-beat packets from requester 1.
        do_reset();
        acc_cyc.delete();
        b0 = out_beats;
        for (int p = 0; p < 5; p++) push_pkt(1, p, 1);
        for (int p = 0; p < 5; p++) send_pkt(1, p, 1);
        cycles(3);
        for (int i = 1; i < 5; i++) check("single_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(2));
        check("t2_beats", 64'(out_beats - b0), 64'(5));
        check("t2_count1", 64'(pkt_count[CW +: CW]), 64'(5));
        check("t2_count0", 64'(pkt_count[0 +: CW]), 64'(0));

        // Backpressure 1,0,0,1 during a 4-beat packet.
        do_reset();
        b0 = out_beats;
        push_pkt(0, 2, 4);
        fork
            send_pkt(0, 2, 4);
            begin
                int t = 0;
                while (!out_valid && t < 50) begin @(negedge clk); t++; end
                @(posedge clk); #1 out_ready = 1'b0;
                @(posedge clk); #1 out_ready = 1'b0;
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        cycles(4);
        check("t3_beats", 64'(out_beats - b0), 64'(4));
        check("t3_drained", 64'(exp_q.size()), 64'(0));

        // Orphan beat from enabled requester 0 while IDLE.
        do_reset();
        orphan_cnt = 0;
        b0 = out_beats;
        in_valid[0] = 1'b1; in_sop[0] = 1'b0; in_eop[0] = 1'b0;
        in_data[0 +: DW] = 32'hDEAD0001;
        @(negedge clk);
        check("orphan_ready", 64'(in_ready[0]), 64'(1));
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        cycles(4);
        check("orphan_pulses", 64'(orphan_cnt), 64'(1));
        check("orphan_no_out", 64'(out_beats - b0), 64'(0));
        check("orphan_counts", 64'(pkt_count), 64'(0));

        // Disable requester 0 mid-packet while requester 1 waits.
        do_reset();
        push_pkt(0, 3, 4);
        push_pkt(1, 3, 2);
        fork
            send_pkt(0, 3, 4);
            begin cycles(1); send_pkt(1, 3, 2); end
            begin
                int t = 0;
                while (grant != 2'b01 && t < 50) begin @(negedge clk); t++; end
                cycles(2);
                req_enable[0] = 1'b0;
            end
        join
        cycles(3);
        in_valid[0] = 1'b1; in_sop[0] = 1'b1; in_eop[0] = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (grant[0] || in_ready[0]) bad = 1;
        end
        check("disabled_never_granted", 64'(bad), 64'(0));
        check("t5_count0", 64'(pkt_count[0 +: CW]), 64'(1));
        check("t5_count1", 64'(pkt_count[CW +: CW]), 64'(1));
        @(posedge clk); #1;
        req_enable[0] = 1'b1;
        push_pkt(0, 4, 1);
        send_pkt(0, 4, 1);
        cycles(3);
        check("t5_reenabled", 64'(pkt_count[0 +: CW]), 64'(2));
        check("t5_drained", 64'(exp_q.size()), 64'(0));

        // Reset mid-packet: every output reads 0 while rst is high.
        sb_en = 0;
        in_valid[0] = 1'b1; in_sop[0] = 1'b1; in_eop[0] = 1'b0;
        cycles(2);
        in_sop[0] = 1'b0;
        cycles(1);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        in_valid = '0; in_sop = '0;
        cycles(1);
        rst = 1'b0;
        cycles(2);
        exp_q.delete();
        stall_prev = 0;
        sb_en = 1;

        // Counter wrap at all-ones (CNT_WIDTH=8 here).
        for (int p = 0; p < 255; p++) begin
            push_pkt(0, p, 1);
            send_pkt(0, p, 1);
        end
        cycles(2);
        check("count_preload", 64'(pkt_count[0 +: CW]), 64'(8'hFF));
        push_pkt(0, 255, 1);
        send_pkt(0, 255, 1);
        cycles(3);
        check("count_wrap", 64'(pkt_count[0 +: CW]), 64'(0));
        check("count_other", 64'(pkt_count[CW +: CW]), 64'(0));
        check("final_drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
